// File: rtl/byte_packer_pkg.sv
// Shared constants and types for the byte packer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package byte_packer_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_LANES      = 4;

    // Width needed to count 0..LANES valid lanes.
    function automatic int cnt_width(input int lanes);
        return $clog2(lanes + 1);
    endfunction

    localparam int CNT_W = $clog2(DEF_LANES + 1);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/byte_packer_lane_parity.sv
// Per-lane even-parity generator for the packed output word.
// Latency: combinational; the caller registers the result alongside the data.
// Backpressure: none (pure function of its input).
module lane_parity
    import byte_packer_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int LANES      = DEF_LANES
) (
    input  logic [LANES-1:0][DATA_WIDTH-1:0] lanes,
    output logic [LANES-1:0]                 parity
);

    // Even parity: the bit that makes each lane plus its parity bit have an even number of ones.
    always_comb begin
        parity = '0;
        for (int i = 0; i < LANES; i++) begin
            parity[i] = ^lanes[i];
        end
    end

endmodule

// File: rtl/byte_packer.sv
// Packs bytes read from an upstream FIFO into LANES-wide words; flush emits a partial word.
// Latency: a full word is valid 5 cycles after the first of 4 back-to-back reads (1 byte/cycle).
// Backpressure: holds the word until out_ready; no FIFO reads while held. BYTE_PACKER_PARITY_EN adds out_parity.
module byte_packer
    import byte_packer_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int LANES      = DEF_LANES
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          fifo_empty,
    output logic                          fifo_rd_en,
    input  logic [DATA_WIDTH-1:0]         fifo_data,
    input  logic                          flush,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_WIDTH*LANES-1:0]   out_data,
    output logic [$clog2(LANES+1)-1:0]    out_count
`ifdef BYTE_PACKER_PARITY_EN
    ,
    output logic [LANES-1:0]              out_parity
`endif
);

    localparam int            CW      = cnt_width(LANES);
    localparam logic [CW:0]   LANES_W = (CW+1)'(LANES);
    localparam logic [CW-1:0] LAST    = CW'(LANES - 1);

    state_t                          state_q, state_n;
    logic [CW-1:0]                   fill_q, fill_n;
    logic                            pend_q, pend_n;
    logic                            flush_pend_q, flush_pend_n;
    logic [LANES-1:0][DATA_WIDTH-1:0] lanes_q, lanes_n;
    logic [CW:0]                     occ;
    logic                            rd_en;

    // Next-state, read request and lane capture; a read issued this cycle is captured next cycle.
    always_comb begin
        state_n      = state_q;
        fill_n       = fill_q;
        lanes_n      = lanes_q;
        flush_pend_n = flush_pend_q | flush;
        occ          = {1'b0, fill_q} + {{CW{1'b0}}, pend_q};
        rd_en        = !rst && (state_q == FILL) && !fifo_empty && !flush_pend_q && (occ < LANES_W);
        pend_n       = rd_en;

        // pend only ever sets in FILL, so a capture never lands in HOLD.
        if (pend_q) begin
            for (int i = 0; i < LANES; i++) begin
                if (fill_q == CW'(i)) begin
                    lanes_n[i] = fifo_data;
                end
            end
            fill_n = fill_q + CW'(1);
        end

        case (state_q)
            FILL: begin
                if (pend_q && (fill_q == LAST)) begin
                    // Full word wins over a coincident flush; the flush is consumed.
                    state_n      = HOLD;
                    flush_pend_n = 1'b0;
                end else if (flush_pend_q && !pend_q) begin
                    if (fill_q != '0) begin
                        state_n = HOLD;
                    end
                    // Either emitting the partial word or nothing to flush.
                    flush_pend_n = 1'b0;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_n = FILL;
                    fill_n  = '0;
                    lanes_n = '0;
                end
            end
            default: state_n = FILL;
        endcase
    end

    // State and datapath registers; reset drops partial/held words and any in-flight read.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FILL;
            fill_q       <= '0;
            pend_q       <= 1'b0;
            flush_pend_q <= 1'b0;
            lanes_q      <= '0;
        end else begin
            state_q      <= state_n;
            fill_q       <= fill_n;
            pend_q       <= pend_n;
            flush_pend_q <= flush_pend_n;
            lanes_q      <= lanes_n;
        end
    end

    assign fifo_rd_en = rd_en;
    assign out_valid  = (state_q == HOLD);
    assign out_data   = lanes_q;
    assign out_count  = fill_q;

`ifdef BYTE_PACKER_PARITY_EN
    logic [LANES-1:0] par_n, par_q;

    lane_parity #(
        .DATA_WIDTH (DATA_WIDTH),
        .LANES      (LANES)
    ) u_lane_parity (
        .lanes  (lanes_n),
        .parity (par_n)
    );

    // Parity registered from the same next-lane values as out_data so the two always agree.
    always_ff @(posedge clk) begin
        if (rst) begin
            par_q <= '0;
        end else begin
            par_q <= par_n;
        end
    end

    assign out_parity = par_q;
`endif

endmodule
